// File: rtl/led_pkg.sv
// Purpose: shared channel indices, fade state encoding and level step helper for led_fader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   LED_CH_R/G/B  bit positions of each colour in the per-channel vectors
//   fade_state_t  observable per-channel fade state
//   sat_step()    one saturating level move toward a target
package led_pkg;

  localparam int LED_CH_R   = 0;
  localparam int LED_CH_G   = 1;
  localparam int LED_CH_B   = 2;
  localparam int LED_NUM_CH = 3;

  typedef enum logic [1:0] {
    IDLE_OFF = 2'd0,
    RISING   = 2'd1,
    IDLE_ON  = 2'd2,
    FALLING  = 2'd3
  } fade_state_t;

  // Move level one step toward target without overshooting it. The
  // arithmetic runs at 32 bits, far wider than any level, so a step past
  // either end is clamped instead of wrapping.
  function automatic int unsigned sat_step(input int unsigned level,
                                           input int unsigned target,
                                           input int unsigned step);
    int unsigned nxt;
    nxt = level;
    if (level < target) begin
      nxt = level + step;
      if (nxt > target) nxt = target;
    end else if (level > target) begin
      if ((level - target) > step) nxt = level - step;
      else                         nxt = target;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// Purpose: one colour channel: request register, brightness level ramp and PWM compare.
// Latency: request -> target 1 clk; level moves only on fade ticks; o_raw is combinational from level.
// Backpressure: none; the request is sampled every clock.
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_led           on/off request
//   i_fade_tick     one-cycle strobe that allows a level step
//   i_pwm_cnt       shared free-running PWM counter
//   o_raw           un-inverted PWM level for this channel
//   o_moving        level differs from target (rising or falling)
module fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_led,
  input  logic                i_fade_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_raw,
  output logic                o_moving
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam int unsigned         STEP    = FADE_STEP;

  logic                led_q;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_nxt;
  fade_state_t         state;

  // The request register is what the ramp follows. A tick on the same edge
  // that this register changes still sees the previous request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) led_q <= 1'b0;
    else          led_q <= i_led;
  end

  assign target    = led_q ? LVL_MAX : '0;
  assign level_nxt = PWM_BITS'(sat_step(32'(level), 32'(target), STEP));

  // Level only moves on a tick, and always from where it currently is, so a
  // request reversal mid-ramp turns the ramp around without a jump.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         level <= '0;
    else if (i_fade_tick) level <= level_nxt;
  end

  // State is derived from level/target; there is no separate state register.
  always_comb begin
    state = IDLE_OFF;
    if (level < target)         state = RISING;
    else if (level > target)    state = FALLING;
    else if (level == LVL_MAX)  state = IDLE_ON;
  end

  assign o_moving = (state == RISING) || (state == FALLING);

  // The compare alone would leave full brightness one count short of
  // always-on, so the top level forces the output high.
  assign o_raw = (level == LVL_MAX) || (i_pwm_cnt < level);

endmodule

// File: rtl/led_fader.sv
// Purpose: turns three on/off LED requests into faded RGB PWM pin drive.
// Latency: request -> target 1 clk; level -> pin 1 clk (registered output); o_busy registered.
// Backpressure: none; free-running, requests sampled every clock.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_led_r/g/b              on/off requests from the blink counter
//   o_led_r/g/b              PWM pin drive, inverted when INVERT=1
//   o_busy                   some channel is still ramping
module led_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int FADE_DIV_BITS = 10,
  parameter int FADE_STEP     = 1,   // legal range 1 .. 2^PWM_BITS-1
  parameter bit INVERT        = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_led_r,
  input  logic i_led_g,
  input  logic i_led_b,
  output logic o_led_r,
  output logic o_led_g,
  output logic o_led_b,
  output logic o_busy
);

  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [FADE_DIV_BITS-1:0] presc;
  logic                     fade_tick;
  logic [LED_NUM_CH-1:0]    req;
  logic [LED_NUM_CH-1:0]    raw;
  logic [LED_NUM_CH-1:0]    moving;
  logic [LED_NUM_CH-1:0]    led_out;
  logic                     busy_q;

  assign req[LED_CH_R] = i_led_r;
  assign req[LED_CH_G] = i_led_g;
  assign req[LED_CH_B] = i_led_b;

  // Both counters free-run and wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pwm_cnt <= '0;
      presc   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      presc   <= presc + 1'b1;
    end
  end

  // Tick on the all-ones count, so after reset the first level step lands
  // exactly 2^FADE_DIV_BITS clocks after release.
  assign fade_tick = &presc;

  fade_channel #(
    .PWM_BITS  (PWM_BITS),
    .FADE_STEP (FADE_STEP)
  ) u_ch_r (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_led       (req[LED_CH_R]),
    .i_fade_tick (fade_tick),
    .i_pwm_cnt   (pwm_cnt),
    .o_raw       (raw[LED_CH_R]),
    .o_moving    (moving[LED_CH_R])
  );

  fade_channel #(
    .PWM_BITS  (PWM_BITS),
    .FADE_STEP (FADE_STEP)
  ) u_ch_g (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_led       (req[LED_CH_G]),
    .i_fade_tick (fade_tick),
    .i_pwm_cnt   (pwm_cnt),
    .o_raw       (raw[LED_CH_G]),
    .o_moving    (moving[LED_CH_G])
  );

  fade_channel #(
    .PWM_BITS  (PWM_BITS),
    .FADE_STEP (FADE_STEP)
  ) u_ch_b (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_led       (req[LED_CH_B]),
    .i_fade_tick (fade_tick),
    .i_pwm_cnt   (pwm_cnt),
    .o_raw       (raw[LED_CH_B]),
    .o_moving    (moving[LED_CH_B])
  );

  // Pins are registered for glitch-free drive; reset puts them at the
  // polarity that keeps the LEDs dark.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_out <= {LED_NUM_CH{INVERT}};
      busy_q  <= 1'b0;
    end else begin
      led_out <= raw ^ {LED_NUM_CH{INVERT}};
      busy_q  <= |moving;
    end
  end

  assign o_led_r = led_out[LED_CH_R];
  assign o_led_g = led_out[LED_CH_G];
  assign o_led_b = led_out[LED_CH_B];
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;
  import led_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut: 4/2/1/0   dut_inv: INVERT=1   dut_s6: FADE_STEP=6   dut_pw: DIV=6, STEP=5
  logic       rst_a = 1'b1, rst_i = 1'b1, rst_s = 1'b1, rst_p = 1'b1;
  logic [2:0] in_a = '0, in_i = '0, in_s = '0, in_p = '0;
  logic [2:0] out_a, out_i, out_s, out_p;
  logic       busy_a, busy_i, busy_s, busy_p;

  led_fader #(.PWM_BITS(4), .FADE_DIV_BITS(2), .FADE_STEP(1), .INVERT(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_a),
    .i_led_r(in_a[0]), .i_led_g(in_a[1]), .i_led_b(in_a[2]),
    .o_led_r(out_a[0]), .o_led_g(out_a[1]), .o_led_b(out_a[2]), .o_busy(busy_a));

  led_fader #(.PWM_BITS(4), .FADE_DIV_BITS(2), .FADE_STEP(1), .INVERT(1'b1)) dut_inv (
    .i_clk(clk), .i_rst_n(rst_i),
    .i_led_r(in_i[0]), .i_led_g(in_i[1]), .i_led_b(in_i[2]),
    .o_led_r(out_i[0]), .o_led_g(out_i[1]), .o_led_b(out_i[2]), .o_busy(busy_i));

  led_fader #(.PWM_BITS(4), .FADE_DIV_BITS(2), .FADE_STEP(6), .INVERT(1'b0)) dut_s6 (
    .i_clk(clk), .i_rst_n(rst_s),
    .i_led_r(in_s[0]), .i_led_g(in_s[1]), .i_led_b(in_s[2]),
    .o_led_r(out_s[0]), .o_led_g(out_s[1]), .o_led_b(out_s[2]), .o_busy(busy_s));

  led_fader #(.PWM_BITS(4), .FADE_DIV_BITS(6), .FADE_STEP(5), .INVERT(1'b0)) dut_pw (
    .i_clk(clk), .i_rst_n(rst_p),
    .i_led_r(in_p[0]), .i_led_g(in_p[1]), .i_led_b(in_p[2]),
    .o_led_r(out_p[0]), .o_led_g(out_p[1]), .o_led_b(out_p[2]), .o_busy(busy_p));

  logic [3:0] lvl_ar, lvl_ag, lvl_ab, lvl_ir, lvl_s6, lvl_pw;
  assign lvl_ar = dut.u_ch_r.level;
  assign lvl_ag = dut.u_ch_g.level;
  assign lvl_ab = dut.u_ch_b.level;
  assign lvl_ir = dut_inv.u_ch_r.level;
  assign lvl_s6 = dut_s6.u_ch_r.level;
  assign lvl_pw = dut_pw.u_ch_r.level;

  // Fade states visited by the red channel of the main instance.
  logic [3:0] cov_a = '0;
  always @(negedge clk) if (rst_a) cov_a[dut.u_ch_r.state] <= 1'b1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, bad, first, lows, busys;
    logic [2:0] seen_out;
    logic       seen_busy;
    logic [3:0] prev;
    int         got [3];

    #1;
    rst_a = 1'b0; rst_i = 1'b0; rst_s = 1'b0; rst_p = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state
    check_val("rst_out",     int'(out_a), 0);
    check_val("rst_busy",    int'(busy_a), 0);
    check_val("rst_inv_out", int'(out_i), 7);
    check_val("rst_lvl",     int'({lvl_ar, lvl_ag, lvl_ab}), 0);
    rst_a = 1'b1; rst_i = 1'b1; rst_s = 1'b1; rst_p = 1'b1;

    // ---- idle for 200 cycles
    seen_out = '0; seen_busy = 1'b0;
    repeat (200) begin
      @(negedge clk);
      seen_out  = seen_out | out_a;
      seen_busy = seen_busy | busy_a;
    end
    check_val("idle_out",  int'(seen_out), 0);
    check_val("idle_busy", int'(seen_busy), 0);
    check_val("idle_lvl",  int'({lvl_ar, lvl_ag, lvl_ab}), 0);
    check_val("inv_idle",  int'(out_i), 7);

    // ---- red rises to full
    in_a[0] = 1'b1;
    @(negedge clk); check_val("busy_lat1", int'(busy_a), 0);
    @(negedge clk); check_val("busy_lat2", int'(busy_a), 1);
    cyc = 2; prev = lvl_ar; bad = 0;
    while (lvl_ar != 4'd15 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (lvl_ar != prev) begin
        if (lvl_ar != prev + 4'd1) bad++;
        prev = lvl_ar;
      end
    end
    check_val("rise_full",      int'(lvl_ar), 15);
    check_val("rise_time_le61", int'(cyc <= 61), 1);
    check_val("rise_steps",     bad, 0);
    @(negedge clk);
    check_val("full_busy_clr", int'(busy_a), 0);
    check_val("full_out_on",   int'(out_a), 1);
    lows = 0; busys = 0;
    repeat (32) begin
      @(negedge clk);
      if (!out_a[0]) lows++;
      if (busy_a) busys++;
    end
    check_val("full_on_const", lows, 0);
    check_val("full_busy_low", busys, 0);

    // ---- fall to 0, rise to 8, then reverse mid-ramp
    in_a[0] = 1'b0;
    cyc = 0;
    while (lvl_ar != 4'd0 && cyc < 80) begin @(negedge clk); cyc++; end
    check_val("fall_zero", int'(lvl_ar), 0);
    in_a[0] = 1'b1;
    cyc = 0;
    while (lvl_ar != 4'd8 && cyc < 60) begin @(negedge clk); cyc++; end
    check_val("reach8", int'(lvl_ar), 8);
    in_a[0] = 1'b0;
    prev = lvl_ar; bad = 0; first = -1; cyc = 0;
    while (lvl_ar != 4'd0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (lvl_ar != prev) begin
        if (first < 0) first = int'(lvl_ar);
        if (lvl_ar != prev - 4'd1) bad++;
        prev = lvl_ar;
      end
    end
    check_val("rev_first",    first, 7);
    check_val("rev_steps",    bad, 0);
    check_val("rev_zero",     int'(lvl_ar), 0);
    check_val("busy_at_zero", int'(busy_a), 1);
    @(negedge clk);
    check_val("busy_fall",    int'(busy_a), 0);

    // ---- all inputs change in the fade_tick cycle
    cyc = 0;
    while (!dut.fade_tick && cyc < 8) begin @(negedge clk); cyc++; end
    check_val("tick_seen", int'(dut.fade_tick), 1);
    in_a = 3'b111;
    @(negedge clk);    check_val("sim_hold",  int'({lvl_ar, lvl_ag, lvl_ab}), 'h000);
    repeat (4) @(negedge clk); check_val("sim_step1", int'({lvl_ar, lvl_ag, lvl_ab}), 'h111);
    repeat (4) @(negedge clk); check_val("sim_step2", int'({lvl_ar, lvl_ag, lvl_ab}), 'h222);
    repeat (3) @(negedge clk); check_val("tick_phase", int'(dut.fade_tick), 1);
    in_a = 3'b000;
    @(negedge clk);    check_val("sim_rev_hold", int'({lvl_ar, lvl_ag, lvl_ab}), 'h333);
    repeat (4) @(negedge clk); check_val("sim_rev_step", int'({lvl_ar, lvl_ag, lvl_ab}), 'h222);
    check_val("state_cov", int'(cov_a), 15);

    // ---- PWM duty at held levels (tick every 64 clocks, step 5)
    in_p[0] = 1'b1;
    cyc = 0;
    while (lvl_pw != 4'd5 && cyc < 150) begin @(negedge clk); cyc++; end
    check_val("pw_lvl5", int'(lvl_pw), 5);
    check_val("pw_busy", int'(busy_p), 1);
    repeat (2) @(negedge clk);
    lows = 0;
    repeat (16) begin @(negedge clk); if (out_p[0]) lows++; end
    check_val("pw_duty5", lows, 5);
    cyc = 0;
    while (lvl_pw != 4'd10 && cyc < 150) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    lows = 0;
    repeat (16) begin @(negedge clk); if (out_p[0]) lows++; end
    check_val("pw_duty10", lows, 10);
    check_val("pw_gb_dark", int'(out_p[2:1]), 0);

    // ---- INVERT=1 with reset pulsed mid-ramp
    in_i = 3'b111;
    seen_out = '0; cyc = 0;
    while (lvl_ir < 4'd8 && cyc < 60) begin
      @(negedge clk); cyc++;
      seen_out = seen_out | ~out_i;
    end
    check_val("inv_active", int'(seen_out != 3'b000), 1);
    #2 rst_i = 1'b0;
    #1;
    check_val("inv_rst_out",  int'(out_i), 7);
    check_val("inv_rst_lvl",  int'(lvl_ir), 0);
    check_val("inv_rst_busy", int'(busy_i), 0);
    in_i = 3'b000;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_i != 3'b111 || busy_i || lvl_ir != 4'd0) bad++;
    end
    check_val("inv_quiet", bad, 0);

    // ---- FADE_STEP=6 saturation at both ends
    in_s[0] = 1'b1;
    prev = lvl_s6;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      while (lvl_s6 == prev && cyc < 20) begin @(negedge clk); cyc++; end
      got[k] = int'(lvl_s6); prev = lvl_s6;
    end
    check_val("s6_up0", got[0], 6);
    check_val("s6_up1", got[1], 12);
    check_val("s6_up2", got[2], 15);
    repeat (12) @(negedge clk);
    check_val("s6_ceiling", int'(lvl_s6), 15);
    in_s[0] = 1'b0;
    prev = lvl_s6;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      while (lvl_s6 == prev && cyc < 20) begin @(negedge clk); cyc++; end
      got[k] = int'(lvl_s6); prev = lvl_s6;
    end
    check_val("s6_dn0", got[0], 9);
    check_val("s6_dn1", got[1], 3);
    check_val("s6_dn2", got[2], 0);
    repeat (12) @(negedge clk);
    check_val("s6_floor",    int'(lvl_s6), 0);
    check_val("s6_busy_end", int'(busy_s), 0);
    check_val("s6_out_dark", int'(out_s), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
